sa_az_sequencer: RTL and testbench

SA_AZ_SEQUENCER -- requirements
Module: sa_az_sequencer

---
 rtl/sa_az_sequencer_if.sv | 49 ++++
 rtl/sa_az_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_sa_az_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sa_az_sequencer_if.sv
// Signal bundle between the auto-zero sequencer and its controller/ADC side.
// The sequencer connects through the slave modport; the controller or bench drives through master.
interface sa_az_sequencer_if #(
  parameter int PC_W = 24
);
  logic            arm_i;
  logic [PC_W-1:0] p_clk_count_precharge;
  logic [3:0]      p_azmux_hi;
  logic [3:0]      p_azmux_lo;
  logic [1:0]      p_pc_sel;
  logic            adc_measure_valid_i;

  logic [3:0]      azmux_o;
  logic [1:0]      sw_pc_o;
  logic            adc_measure_trig_o;
  logic            meas_complete_o;
  logic [2:0]      status_o;
  logic [15:0]     pair_count_o;

  modport slave (
    input  arm_i,
    input  p_clk_count_precharge,
    input  p_azmux_hi,
    input  p_azmux_lo,
    input  p_pc_sel,
    input  adc_measure_valid_i,
    output azmux_o,
    output sw_pc_o,
    output adc_measure_trig_o,
    output meas_complete_o,
    output status_o,
    output pair_count_o
  );

  modport master (
    output arm_i,
    output p_clk_count_precharge,
    output p_azmux_hi,
    output p_azmux_lo,
    output p_pc_sel,
    output adc_measure_valid_i,
    input  azmux_o,
    input  sw_pc_o,
    input  adc_measure_trig_o,
    input  meas_complete_o,
    input  status_o,
    input  pair_count_o
  );
endinterface

// File: rtl/sa_az_sequencer.sv
// Auto-zero hi/lo pair sequencer: precharge, sample signal, settle, sample zero, repeat while armed.
// Every output is a flop whose next value is derived from the next state, so outputs track the state register.
module sa_az_sequencer #(
  parameter int          PC_W       = 24,
  parameter logic [3:0]  PARK_AZMUX = 4'b0000
) (
  input  logic                clk,
  input  logic                reset,
  sa_az_sequencer_if.slave    bus
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRECHARGE = 3'd1,
    ST_HI_SAMPLE = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_LO_SAMPLE = 3'd4
  } state_e;

  // An illegal both-switches-closed select collapses to pc1 only.
  function automatic logic [1:0] pc_onehot(input logic [1:0] sel);
    logic [1:0] r;
    case (sel)
      2'b11:   r = 2'b01;
      default: r = sel;
    endcase
    return r;
  endfunction

  // Down-counter preload so a phase lasts max(n,1) cycles.
  function automatic logic [PC_W-1:0] count_preload(input logic [PC_W-1:0] n);
    logic [PC_W-1:0] r;
    if (n == {PC_W{1'b0}}) begin
      r = {PC_W{1'b0}};
    end else begin
      r = n - PC_W'(1);
    end
    return r;
  endfunction

  state_e          state_q, state_d;
  logic [PC_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0] n_q, n_d;
  logic [3:0]      hi_q, hi_d;
  logic [3:0]      lo_q, lo_d;
  logic [1:0]      sel_q, sel_d;
  logic [3:0]      azmux_q, azmux_d;
  logic [1:0]      sw_q, sw_d;
  logic            trig_q, trig_d;
  logic            mc_q, mc_d;
  logic [2:0]      status_q, status_d;
  logic [15:0]     pair_q, pair_d;
  logic            enter_pc_s;
  logic            valid_ok_s;

  // trig_q is high exactly in the first cycle of a sample state, so it doubles as the ignore-valid window.
  assign valid_ok_s = bus.adc_measure_valid_i & ~trig_q;

  // Next-state, parameter latch and counter logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    n_d        = n_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    sel_d      = sel_q;
    mc_d       = 1'b0;
    pair_d     = pair_q;
    enter_pc_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.arm_i) begin
          state_d    = ST_PRECHARGE;
          pair_d     = 16'd0;
          enter_pc_s = 1'b1;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_PRECHARGE: begin
        if (cnt_q == {PC_W{1'b0}}) begin
          state_d = ST_HI_SAMPLE;
        end else begin
          cnt_d   = cnt_q - PC_W'(1);
        end
      end
      ST_HI_SAMPLE: begin
        if (valid_ok_s) begin
          state_d = ST_SETTLE;
          cnt_d   = count_preload(n_q);
        end else begin
          state_d = ST_HI_SAMPLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == {PC_W{1'b0}}) begin
          state_d = ST_LO_SAMPLE;
        end else begin
          cnt_d   = cnt_q - PC_W'(1);
        end
      end
      ST_LO_SAMPLE: begin
        if (valid_ok_s) begin
          mc_d   = 1'b1;
          pair_d = pair_q + 16'd1;
          if (bus.arm_i) begin
            state_d    = ST_PRECHARGE;
            enter_pc_s = 1'b1;
          end else begin
            state_d    = ST_IDLE;
          end
        end else begin
          state_d = ST_LO_SAMPLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (enter_pc_s) begin
      n_d   = bus.p_clk_count_precharge;
      hi_d  = bus.p_azmux_hi;
      lo_d  = bus.p_azmux_lo;
      sel_d = pc_onehot(bus.p_pc_sel);
      cnt_d = count_preload(bus.p_clk_count_precharge);
    end else begin
      n_d   = n_q;
    end
  end

  // Output decode from the next state so the registered outputs line up with the state register.
  always_comb begin
    azmux_d  = PARK_AZMUX;
    sw_d     = 2'b00;
    trig_d   = 1'b0;
    status_d = {1'b0, 1'b0, bus.arm_i};

    case (state_d)
      ST_IDLE: begin
        azmux_d = PARK_AZMUX;
      end
      ST_PRECHARGE: begin
        azmux_d     = hi_d;
        status_d[2] = 1'b1;
      end
      ST_HI_SAMPLE: begin
        azmux_d     = hi_d;
        sw_d        = sel_d;
        trig_d      = (state_q != ST_HI_SAMPLE);
        status_d[2] = 1'b1;
      end
      ST_SETTLE: begin
        azmux_d     = lo_d;
        status_d[2] = 1'b1;
        status_d[1] = 1'b1;
      end
      ST_LO_SAMPLE: begin
        azmux_d     = lo_d;
        trig_d      = (state_q != ST_LO_SAMPLE);
        status_d[2] = 1'b1;
        status_d[1] = 1'b1;
      end
      default: begin
        azmux_d = PARK_AZMUX;
      end
    endcase
  end

  // State, latched parameters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {PC_W{1'b0}};
      n_q      <= {PC_W{1'b0}};
      hi_q     <= 4'd0;
      lo_q     <= 4'd0;
      sel_q    <= 2'b00;
      azmux_q  <= PARK_AZMUX;
      sw_q     <= 2'b00;
      trig_q   <= 1'b0;
      mc_q     <= 1'b0;
      status_q <= 3'b000;
      pair_q   <= 16'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      sel_q    <= sel_d;
      azmux_q  <= azmux_d;
      sw_q     <= sw_d;
      trig_q   <= trig_d;
      mc_q     <= mc_d;
      status_q <= status_d;
      pair_q   <= pair_d;
    end
  end

  assign bus.azmux_o            = azmux_q;
  assign bus.sw_pc_o            = sw_q;
  assign bus.adc_measure_trig_o = trig_q;
  assign bus.meas_complete_o    = mc_q;
  assign bus.status_o           = status_q;
  assign bus.pair_count_o       = pair_q;

endmodule

// File: tb/tb_sa_az_sequencer.sv
// Self-checking bench for sa_az_sequencer: each pair's expected output timeline is
// computed from phase lengths (max(N,1), trig-to-valid delays) rather than from a state machine.
module tb_sa_az_sequencer;

  localparam int         PC_W = 24;
  localparam logic [3:0] PARK = 4'hA;

  typedef struct packed {
    logic [3:0]  azmux;
    logic [1:0]  sw;
    logic        trig;
    logic        mc;
    logic [2:0]  st;
    logic [15:0] cnt;
  } out_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic arm_seen;
  out_t obs;
  out_t e;

  always #5 clk = ~clk;

  sa_az_sequencer_if #(.PC_W(PC_W)) bus ();

  sa_az_sequencer #(.PC_W(PC_W), .PARK_AZMUX(PARK)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock one edge and capture outputs 1 time unit later.
  task automatic tick();
    arm_seen = bus.arm_i;
    @(posedge clk);
    #1;
    obs = {bus.azmux_o, bus.sw_pc_o, bus.adc_measure_trig_o, bus.meas_complete_o,
           bus.status_o, bus.pair_count_o};
  endtask

  function automatic int plen(int n);
    return (n < 1) ? 1 : n;
  endfunction

  // Expected outputs at cycle i of a pair (cycle 0 = first PRECHARGE cycle).
  function automatic out_t model(int i, int p, int d1, int d2, logic [3:0] hi, logic [3:0] lo,
                                 logic [1:0] sel, logic [15:0] cnt, logic mc0, logic arm_r);
    out_t r;
    int hs = p;
    int ss = p + d1 + 1;
    int ls = 2 * p + d1 + 1;
    r.cnt  = cnt;
    r.mc   = mc0 && (i == 0);
    r.trig = 1'b0;
    r.sw   = 2'b00;
    if (i < hs) begin
      r.azmux = hi; r.st = {2'b10, arm_r};
    end else if (i < ss) begin
      r.azmux = hi; r.sw = (sel == 2'b11) ? 2'b01 : sel;
      r.trig = (i == hs); r.st = {2'b10, arm_r};
    end else if (i < ls) begin
      r.azmux = lo; r.st = {2'b11, arm_r};
    end else begin
      r.azmux = lo; r.trig = (i == ls); r.st = {2'b11, arm_r};
    end
    return r;
  endfunction

  function automatic out_t idle_exp(logic [15:0] cnt, logic mc, logic arm_r);
    out_t r;
    r.azmux = PARK; r.sw = 2'b00; r.trig = 1'b0; r.mc = mc;
    r.st = {2'b00, arm_r}; r.cnt = cnt;
    return r;
  endfunction

  function automatic int pair_len(int p, int d1, int d2);
    return 2 * p + d1 + d2 + 2;
  endfunction

  // Valid pulses that should be honoured: d cycles after each trig.
  function automatic logic vpos(int i, int p, int d1, int d2);
    return (i == p + d1) || (i == 2 * p + d1 + d2 + 1);
  endfunction

  task automatic set_params(int n, logic [3:0] hi, logic [3:0] lo, logic [1:0] sel);
    bus.p_clk_count_precharge = PC_W'(n);
    bus.p_azmux_hi = hi;
    bus.p_azmux_lo = lo;
    bus.p_pc_sel   = sel;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.arm_i = 1'b0;
    bus.adc_measure_valid_i = 1'b0;
    set_params(0, 4'h0, 4'h0, 2'b00);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (obs !== idle_exp(16'd0, 1'b0, 1'b0)) begin
        n_fail++; $display("FAIL reset_state i=%0d got %h exp %h", i, obs, idle_exp(16'd0, 1'b0, 1'b0));
      end
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if (obs !== idle_exp(16'd0, 1'b0, 1'b0)) begin
      n_fail++; $display("FAIL reset_release got %h exp %h", obs, idle_exp(16'd0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_basic_pair();
    int p = plen(3);
    int l = pair_len(p, 10, 10);
    set_params(3, 4'h5, 4'h1, 2'b01);
    bus.arm_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < l; i++) begin
        tick();
        e = model(i, p, 10, 10, 4'h5, 4'h1, 2'b01, 16'(k), (k > 0), arm_seen);
        n_cmp++;
        if (obs !== e) begin
          n_fail++; $display("FAIL basic_pair k=%0d i=%0d got %h exp %h", k, i, obs, e);
        end
        bus.adc_measure_valid_i = vpos(i, p, 10, 10);
        if (k == 1 && i == l - 1) bus.arm_i = 1'b0;
      end
    end
    tick();
    bus.adc_measure_valid_i = 1'b0;
    n_cmp++;
    if (obs !== idle_exp(16'd2, 1'b1, 1'b0)) begin
      n_fail++; $display("FAIL basic_complete got %h exp %h", obs, idle_exp(16'd2, 1'b1, 1'b0));
    end
    tick();
    n_cmp++;
    if (obs !== idle_exp(16'd2, 1'b0, 1'b0)) begin
      n_fail++; $display("FAIL basic_idle got %h exp %h", obs, idle_exp(16'd2, 1'b0, 1'b0));
    end
  endtask

  task automatic test_zero_count();
    int p = plen(0);
    int l = pair_len(p, 1, 1);
    set_params(0, 4'h7, 4'h2, 2'b10);
    bus.arm_i = 1'b1;
    for (int i = 0; i < l; i++) begin
      tick();
      e = model(i, p, 1, 1, 4'h7, 4'h2, 2'b10, 16'd0, 1'b0, arm_seen);
      n_cmp++;
      if (obs !== e) begin
        n_fail++; $display("FAIL zero_count i=%0d got %h exp %h", i, obs, e);
      end
      bus.adc_measure_valid_i = vpos(i, p, 1, 1);
      if (i == l - 1) bus.arm_i = 1'b0;
    end
    tick();
    bus.adc_measure_valid_i = 1'b0;
    n_cmp++;
    if (obs !== idle_exp(16'd1, 1'b1, 1'b0)) begin
      n_fail++; $display("FAIL zero_complete got %h exp %h", obs, idle_exp(16'd1, 1'b1, 1'b0));
    end
  endtask

  task automatic test_arm_drop();
    int p = plen(2);
    int l = pair_len(p, 4, 3);
    set_params(2, 4'h9, 4'h3, 2'b01);
    bus.arm_i = 1'b1;
    for (int i = 0; i < l; i++) begin
      tick();
      e = model(i, p, 4, 3, 4'h9, 4'h3, 2'b01, 16'd0, 1'b0, arm_seen);
      n_cmp++;
      if (obs !== e) begin
        n_fail++; $display("FAIL arm_drop i=%0d got %h exp %h", i, obs, e);
      end
      bus.adc_measure_valid_i = vpos(i, p, 4, 3);
      if (i == p + 1) bus.arm_i = 1'b0;
    end
    tick();
    bus.adc_measure_valid_i = 1'b0;
    n_cmp++;
    if (obs !== idle_exp(16'd1, 1'b1, 1'b0)) begin
      n_fail++; $display("FAIL arm_drop_complete got %h exp %h", obs, idle_exp(16'd1, 1'b1, 1'b0));
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (obs !== idle_exp(16'd1, 1'b0, 1'b0)) begin
        n_fail++; $display("FAIL arm_drop_idle i=%0d got %h exp %h", i, obs, idle_exp(16'd1, 1'b0, 1'b0));
      end
    end
  endtask

  task automatic test_spurious_valid();
    int p = plen(2);
    int l = pair_len(p, 5, 4);
    bus.adc_measure_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (obs !== idle_exp(16'd1, 1'b0, 1'b0)) begin
        n_fail++; $display("FAIL spurious_idle i=%0d got %h exp %h", i, obs, idle_exp(16'd1, 1'b0, 1'b0));
      end
    end
    bus.adc_measure_valid_i = 1'b0;
    set_params(2, 4'h4, 4'h8, 2'b10);
    bus.arm_i = 1'b1;
    for (int i = 0; i < l; i++) begin
      tick();
      e = model(i, p, 5, 4, 4'h4, 4'h8, 2'b10, 16'd0, 1'b0, arm_seen);
      n_cmp++;
      if (obs !== e) begin
        n_fail++; $display("FAIL spurious_pair i=%0d got %h exp %h", i, obs, e);
      end
      bus.adc_measure_valid_i = vpos(i, p, 5, 4) || (i == p) ||
                                (i >= p + 6 && i < 2 * p + 6) || (i == 2 * p + 6);
      if (i == l - 1) bus.arm_i = 1'b0;
    end
    tick();
    bus.adc_measure_valid_i = 1'b0;
    n_cmp++;
    if (obs !== idle_exp(16'd1, 1'b1, 1'b0)) begin
      n_fail++; $display("FAIL spurious_complete got %h exp %h", obs, idle_exp(16'd1, 1'b1, 1'b0));
    end
  endtask

  task automatic test_reset_mid_lo();
    int p = plen(1);
    int ls = 2 * p + 2 + 1;
    set_params(1, 4'hB, 4'hD, 2'b01);
    bus.arm_i = 1'b1;
    for (int i = 0; i < ls + 4; i++) begin
      tick();
      e = model(i, p, 2, 20, 4'hB, 4'hD, 2'b01, 16'd0, 1'b0, arm_seen);
      n_cmp++;
      if (obs !== e) begin
        n_fail++; $display("FAIL rst_lo_pair i=%0d got %h exp %h", i, obs, e);
      end
      bus.adc_measure_valid_i = (i == p + 2);
    end
    reset = 1'b1;
    bus.arm_i = 1'b0;
    tick();
    reset = 1'b0;
    n_cmp++;
    if (obs !== idle_exp(16'd0, 1'b0, 1'b0)) begin
      n_fail++; $display("FAIL rst_lo_reset got %h exp %h", obs, idle_exp(16'd0, 1'b0, 1'b0));
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.adc_measure_valid_i = (i == 0);
      n_cmp++;
      if (obs !== idle_exp(16'd0, 1'b0, 1'b0)) begin
        n_fail++; $display("FAIL rst_lo_idle i=%0d got %h exp %h", i, obs, idle_exp(16'd0, 1'b0, 1'b0));
      end
    end
  endtask

  task automatic test_param_change();
    int p = plen(2);
    int l = pair_len(p, 3, 3);
    logic [3:0] hi_k;
    set_params(2, 4'h6, 4'h3, 2'b11);
    bus.arm_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      hi_k = (k == 0) ? 4'h6 : 4'hC;
      for (int i = 0; i < l; i++) begin
        tick();
        e = model(i, p, 3, 3, hi_k, 4'h3, 2'b11, 16'(k), (k > 0), arm_seen);
        n_cmp++;
        if (obs !== e) begin
          n_fail++; $display("FAIL param_change k=%0d i=%0d got %h exp %h", k, i, obs, e);
        end
        bus.adc_measure_valid_i = vpos(i, p, 3, 3);
        if (k == 0 && i == p + 4) bus.p_azmux_hi = 4'hC;
        if (k == 1 && i == l - 1) bus.arm_i = 1'b0;
      end
    end
    tick();
    bus.adc_measure_valid_i = 1'b0;
    n_cmp++;
    if (obs !== idle_exp(16'd2, 1'b1, 1'b0)) begin
      n_fail++; $display("FAIL param_complete got %h exp %h", obs, idle_exp(16'd2, 1'b1, 1'b0));
    end
  endtask

  task automatic test_random();
    int n, p, d1, d2, l;
    logic [3:0] hi, lo;
    logic [1:0] sel;
    int nn; logic [3:0] nhi, nlo; logic [1:0] nsel;
    n = $urandom_range(0, 4); hi = 4'($urandom); lo = 4'($urandom); sel = 2'($urandom);
    set_params(n, hi, lo, sel);
    bus.arm_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      p = plen(n); d1 = $urandom_range(1, 5); d2 = $urandom_range(1, 5);
      l = pair_len(p, d1, d2);
      nn = $urandom_range(0, 4); nhi = 4'($urandom); nlo = 4'($urandom); nsel = 2'($urandom);
      for (int i = 0; i < l; i++) begin
        tick();
        e = model(i, p, d1, d2, hi, lo, sel, 16'(k), (k > 0), arm_seen);
        n_cmp++;
        if (obs !== e) begin
          n_fail++; $display("FAIL random k=%0d i=%0d got %h exp %h", k, i, obs, e);
        end
        bus.adc_measure_valid_i = vpos(i, p, d1, d2) ||
          (((i <= p) || (i >= p + d1 + 1 && i <= 2 * p + d1 + 1)) && ($urandom_range(0, 1) == 1));
        if (i == 1) set_params($urandom_range(0, 9), 4'($urandom), 4'($urandom), 2'($urandom));
        if (i == l - 1) begin
          set_params(nn, nhi, nlo, nsel);
          if (k == 5) bus.arm_i = 1'b0;
        end
      end
      n = nn; hi = nhi; lo = nlo; sel = nsel;
    end
    tick();
    bus.adc_measure_valid_i = 1'b0;
    n_cmp++;
    if (obs !== idle_exp(16'd6, 1'b1, 1'b0)) begin
      n_fail++; $display("FAIL random_complete got %h exp %h", obs, idle_exp(16'd6, 1'b1, 1'b0));
    end
  endtask

  initial begin
    test_reset();
    test_basic_pair();
    test_zero_count();
    test_arm_drop();
    test_spurious_valid();
    test_reset_mid_lo();
    test_param_change();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
